onchip_mem_stream_reader: RTL and testbench
===========================================

Name: onchip_mem_stream_reader

Overview:
- Avalon-MM read master that fetches a contiguous block of 32-bit words from the on-chip memory slave and emits them on an Avalon-ST source, one packet per command.
- Sits between the Qsys interconnect (master side) and downstream consumers such as the display and frame pipeline.
- Supports multiple outstanding reads, with credit-limited issue into an internal FIFO, so source backpressure never overflows the buffer.

Parameters:
- ADDR_W, 18, byte-address width of avm_address (covers 51200 x 32-bit words).
- DATA_W, 32, data width; address stride is DATA_W/8.
- CNT_W, 16, width of the word-count field.
- FIFO_DEPTH, 8, read-data buffer depth in words; power of two, ≥2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; accepted only in IDLE.
- start_addr  in  ADDR_W  byte start address; low log2(DATA_W/8) bits ignored (treated as 0).
- word_count  in  CNT_W  number of words to read; 0 is legal.
- busy  out  1  high while a command is in progress.
- done  out  1  one-cycle completion pulse.
- avm_address  out  ADDR_W  master byte address.
- avm_read  out  1  read request.
- avm_byteenable  out  DATA_W/8  constant all ones.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  DATA_W  returned data.
- avm_readdatavalid  in  1  readdata qualifier; variable latency ≥1.
- src_data  out  DATA_W  stream data.
- src_valid  out  1  stream valid.
- src_ready  in  1  stream ready; ready latency 0.
- src_startofpacket  out  1  first word of the command.
- src_endofpacket  out  1  last word of the command.

Behaviour:
- Reset values (synchronous, clk edge with reset=1): state IDLE, busy=0, done=0, avm_read=0, avm_address=0, src_valid=0, SOP=EOP=0, FIFO empty, all counters 0.
- A mid-transfer reset discards outstanding reads; readdatavalid pulses arriving after reset, while in IDLE, are ignored.
- States:
  - IDLE: busy=0. start=1 latches address (aligned), count, and issued/received/sent=0. Goes to READ if count≠0, else DONE.
  - READ: busy=1. Issues reads. Goes to DRAIN on the cycle the count-th read is accepted.
  - DRAIN: busy=1, avm_read=0. Goes to DONE when received==count, sent==count, and the FIFO is empty.
  - DONE: done=1 for exactly one cycle, busy=0. Returns to IDLE.
- start outside IDLE is ignored, with no effect on the current command.
- Read issue:
  - Acceptance = avm_read & ~avm_waitrequest.
  - While waitrequest=1, avm_read and avm_address are held stable.
  - After each acceptance, address += DATA_W/8, wrapping modulo 2^ADDR_W.
- Credit rule: avm_read may be newly asserted only when issued<count and (fifo_used + outstanding) < FIFO_DEPTH.
  - outstanding = accepted reads not yet returned.
  - A request that is already asserted is never withdrawn.
  - Back-to-back acceptances (one per cycle) are allowed when credits permit.
- Every avm_readdatavalid in READ/DRAIN writes avm_readdata into the FIFO. Overflow is impossible by the credit rule; an assertion checks it.
- Stream output:
  - src_valid = FIFO non-empty; src_data = FIFO head.
  - A word pops on src_valid & src_ready.
  - While src_valid=1 and src_ready=0, data, SOP and EOP are held stable.
- Packet marking: SOP=1 on the word with sent index 0; EOP=1 on index count-1. For count=1, SOP and EOP are both 1.
- FIFO push and pop in the same cycle leave fifo_used unchanged. This holds at full and at empty; an empty FIFO does not pop.
- Read-to-output latency: a readdatavalid at cycle t drives src_valid at t+1 (registered FIFO).
- Counters are CNT_W bits wide; the maximum command is 2^CNT_W−1 words.

Test Plan:
- Single word: start, addr=0x100, count=1, slave latency 1, src_ready=1 → one read at 0x100; one beat with SOP=EOP=1 and the memory value; done pulses once; busy returns to 0.
- Streaming: addr=0x0, count=16, waitrequest=0, src_ready=1, latency 1 → addresses 0x0..0x3C in stride 4; 16 beats in order; SOP on beat 0, EOP on beat 15; at most FIFO_DEPTH reads outstanding.
- Backpressure and stalls: count=20, src_ready toggles 1 cycle in 3, random waitrequest, latency 1–4 → avm_address stable during waitrequest; never more than 8 words buffered or outstanding; data matches memory; no loss or duplication.
- Zero count and start-while-busy: count=0 → no avm_read, done at the cycle after start. Then start count=4, with a second start on the cycle after → only the 4-word packet is produced.
- Address wrap: start_addr=0x3FFF8, count=4 → addresses 0x3FFF8, 0x3FFFC, 0x00000, 0x00004.
- Reset mid-operation: count=32, assert reset with 3 reads outstanding, then send late readdatavalid pulses → all outputs at reset values; no src_valid; the next command (count=2) completes normally.

Source files
------------

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM burst-free read master: fetches word_count consecutive words and
// replays them as one Avalon-ST packet through a credit-limited read buffer.
module onchip_mem_stream_reader #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [CNT_W-1:0]      word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic [DATA_W-1:0]     src_data,
  output logic                  src_valid,
  input  logic                  src_ready,
  output logic                  src_startofpacket,
  output logic                  src_endofpacket
);

  localparam int BYTES = DATA_W / 8;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int UW    = PW + 1;
  localparam logic [UW:0] DEPTH_C = (UW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              state, state_next;
  logic                req, req_next;
  logic [ADDR_W-1:0]   addr;
  logic [CNT_W-1:0]    count, issued, received, sent, issued_next;
  logic [UW-1:0]       used, outstanding, used_next, outstanding_next;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic                accept, push, pop, credit_ok;

  assign accept           = req & ~avm_waitrequest;
  // Late returns after a reset land in IDLE and must not touch the buffer.
  assign push             = (state == S_READ || state == S_DRAIN) && avm_readdatavalid;
  assign src_valid        = (used != '0);
  assign pop              = src_valid & src_ready;
  assign used_next        = used + UW'(push) - UW'(pop);
  assign outstanding_next = outstanding + UW'(accept) - UW'(push);
  assign issued_next      = issued + CNT_W'(accept);
  // Buffered words plus reads in flight can never exceed the buffer depth.
  assign credit_ok        = ({1'b0, used_next} + {1'b0, outstanding_next}) < DEPTH_C;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    state_next = state;
    req_next   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (word_count == '0) state_next = S_DONE;
          else                  state_next = S_READ;
          req_next = (word_count != '0);
        end
      end
      S_READ: begin
        if (req && avm_waitrequest) req_next = 1'b1;
        else                        req_next = (issued_next < count) && credit_ok;
        if (accept && issued_next == count) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (received == count && sent == count && used == '0) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all of them update from the same pre-edge values.
    if (reset) begin
      state       <= S_IDLE;
      req         <= 1'b0;
      addr        <= '0;
      count       <= '0;
      issued      <= '0;
      received    <= '0;
      sent        <= '0;
      used        <= '0;
      outstanding <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state       <= state_next;
      req         <= req_next;
      used        <= used_next;
      outstanding <= outstanding_next;
      if (state == S_IDLE && start) begin
        addr     <= start_addr & ~ADDR_W'(BYTES - 1);
        count    <= word_count;
        issued   <= '0;
        received <= '0;
        sent     <= '0;
      end else begin
        if (accept) begin
          addr   <= addr + ADDR_W'(BYTES);
          issued <= issued_next;
        end
        if (push) begin
          received <= received + CNT_W'(1);
          wr_ptr   <= wr_ptr + PW'(1);
        end
        if (pop) begin
          sent   <= sent + CNT_W'(1);
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
    end
  end

  // NOTE: the data array has no reset; validity is tracked solely by the reset pointers and used count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= avm_readdata;
  end

  assign busy              = (state == S_READ) || (state == S_DRAIN);
  assign done              = (state == S_DONE);
  assign avm_read          = req;
  assign avm_address       = addr;
  assign avm_byteenable    = '1;
  assign src_data          = mem[rd_ptr];
  assign src_startofpacket = src_valid && (sent == '0);
  assign src_endofpacket   = src_valid && (sent == count - CNT_W'(1));

  no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && used == UW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Bench for onchip_mem_stream_reader: table of commands plus random ones, an
// Avalon slave with random stalls/latency, and a queue-based packet model.
module tb_onchip_mem_stream_reader;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   start_addr = '0;
  logic [CNT_W-1:0]    word_count = '0;
  logic                busy, done, avm_read, avm_waitrequest, avm_readdatavalid;
  logic [ADDR_W-1:0]   avm_address;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [DATA_W-1:0]   avm_readdata, src_data;
  logic                src_valid, src_ready, src_startofpacket, src_endofpacket;

  onchip_mem_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .word_count(word_count),
    .busy(busy), .done(done), .avm_address(avm_address), .avm_read(avm_read),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .src_startofpacket(src_startofpacket), .src_endofpacket(src_endofpacket));

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int count, wait_pct, ready_pct, ready_period, lat_min, lat_max;
    logic [ADDR_W-1:0] exp_first, exp_last;
  } vec_t;
  typedef struct { logic [DATA_W-1:0] data; logic sop, eop; } beat_t;
  typedef struct { logic [DATA_W-1:0] data; int ready; int gen; } rsp_t;

  logic [ADDR_W-1:0] exp_addr_q[$];
  beat_t             exp_beat_q[$];
  rsp_t              pend_q[$];

  int wait_pct = 0, ready_pct = 100, ready_period = 0, lat_min = 1, lat_max = 1;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, gen = 0, rv_gen = -1, last_ready = 0;
  int acc_n = 0, rv_n = 0, pop_n = 0, max_occ = 0, done_n = 0, beats_n = 0, cmd_acc = 0;
  logic [ADDR_W-1:0] first_addr = '0, last_addr = '0, prev_addr = '0;
  logic prev_wait_stall = 1'b0, prev_src_stall = 1'b0;
  logic [DATA_W+1:0] prev_beat = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] info);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event, value 0x%0h (t=%0t)", name, info, $time);
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return (DATA_W'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Observes the cycle's handshakes; everything seen here takes effect at the next rising edge.
  task automatic monitor_step();
    rsp_t  r;
    beat_t b;
    int    t;
    if (prev_wait_stall) check("addr_hold_in_wait", {avm_read, avm_address}, {1'b1, prev_addr});
    prev_wait_stall = avm_read && avm_waitrequest;
    prev_addr       = avm_address;
    if (prev_src_stall) check("src_hold_in_backpressure",
                              {src_data, src_startofpacket, src_endofpacket}, prev_beat);
    prev_src_stall = src_valid && !src_ready;
    prev_beat      = {src_data, src_startofpacket, src_endofpacket};
    if (avm_read && !avm_waitrequest) begin
      acc_n++;
      if (exp_addr_q.size() == 0) flag("extra_read", 64'(avm_address));
      else check("read_addr", avm_address, exp_addr_q.pop_front());
      if (cmd_acc == 0) first_addr = avm_address;
      last_addr = avm_address;
      cmd_acc++;
      t = cyc + $urandom_range(lat_max, lat_min);
      if (t <= last_ready) t = last_ready + 1;
      last_ready = t;
      r.data = mem_word(avm_address); r.ready = t; r.gen = gen;
      pend_q.push_back(r);
    end
    if (avm_readdatavalid && rv_gen == gen) rv_n++;
    if (src_valid && src_ready) begin
      pop_n++;
      beats_n++;
      if (exp_beat_q.size() == 0) flag("extra_beat", 64'(src_data));
      else begin
        b = exp_beat_q.pop_front();
        check("beat_data_sop_eop", {src_data, src_startofpacket, src_endofpacket}, {b.data, b.sop, b.eop});
      end
    end
    if (done) done_n++;
    if (acc_n - pop_n > max_occ) max_occ = acc_n - pop_n;
  endtask

  task automatic drive_step();
    rsp_t r;
    if (pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
      r = pend_q.pop_front();
      avm_readdatavalid = 1'b1; avm_readdata = r.data; rv_gen = r.gen;
    end else begin
      avm_readdatavalid = 1'b0; avm_readdata = $urandom; rv_gen = -1;
    end
    avm_waitrequest = (int'($urandom_range(99)) < wait_pct);
    if (ready_period > 0) src_ready = (cyc % ready_period == 0);
    else                  src_ready = (int'($urandom_range(99)) < ready_pct);
  endtask

  initial begin
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0; src_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) monitor_step();
      @(posedge clk);
      cyc++;
      #1 drive_step();
    end
  end

  function automatic vec_t mk(input logic [ADDR_W-1:0] a, input int n, input int w, input int rp,
                              input int per, input int lmin, input int lmax,
                              input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
    vec_t v;
    v.addr = a; v.count = n; v.wait_pct = w; v.ready_pct = rp; v.ready_period = per;
    v.lat_min = lmin; v.lat_max = lmax; v.exp_first = f; v.exp_last = l;
    return v;
  endfunction

  // Model: a command is a run of word-aligned addresses, each returning its memory word in order.
  task automatic kick(input logic [ADDR_W-1:0] a, input int n, input bit dup);
    logic [ADDR_W-1:0] base, x;
    beat_t b;
    base = a & ~ADDR_W'(3);
    for (int i = 0; i < n; i++) begin
      x = base + ADDR_W'(4 * i);
      exp_addr_q.push_back(x);
      b.data = mem_word(x); b.sop = (i == 0); b.eop = (i == n - 1);
      exp_beat_q.push_back(b);
    end
    cmd_acc = 0; beats_n = 0; done_n = 0; max_occ = 0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; word_count = CNT_W'(n);
    @(posedge clk); #1;
    start = dup; start_addr = $urandom; word_count = CNT_W'($urandom_range(9, 1));
    if (dup) begin @(posedge clk); #1; start = 1'b0; end
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int k = 0; k < budget && done_n == 0; k++) begin @(posedge clk); #1; end
    if (done_n == 0) $display("FAIL %s_timeout: no done after %0d cycles, beats %0d", name, budget, beats_n);
    if (done_n == 0) begin n_cmp++; n_bad++; end
  endtask

  task automatic finish_cmd(input string name, input int n, input logic [ADDR_W-1:0] f,
                            input logic [ADDR_W-1:0] l);
    repeat (2) begin @(posedge clk); #1; end
    check({name, "_done_pulses"}, done_n, 1);
    check({name, "_busy_idle"}, busy, 0);
    check({name, "_beats"}, beats_n, n);
    check({name, "_reads_left"}, exp_addr_q.size(), 0);
    check({name, "_beats_left"}, exp_beat_q.size(), 0);
    check({name, "_occupancy_le_depth"}, 64'(max_occ <= DEPTH), 1);
    if (n > 0) begin
      check({name, "_first_addr"}, first_addr, f);
      check({name, "_last_addr"}, last_addr, l);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    wait_pct = v.wait_pct; ready_pct = v.ready_pct; ready_period = v.ready_period;
    lat_min = v.lat_min; lat_max = v.lat_max;
    kick(v.addr, v.count, 1'b0);
    check({name, "_busy_after_start"}, busy, 1);
    wait_done(v.count * 60 + 200, name);
    finish_cmd(name, v.count, v.exp_first, v.exp_last);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_avm_read"}, avm_read, 0);
    check({name, "_avm_address"}, avm_address, 0);
    check({name, "_src_valid_sop_eop"}, {src_valid, src_startofpacket, src_endofpacket}, 0);
    check({name, "_byteenable"}, avm_byteenable, 4'hF);
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    logic [ADDR_W-1:0] ra, rf;
    int rn, guard;
    logic saw_valid;

    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic [ADDR_W-1:0] ra, rf;
    int rn, guard;
    logic saw_valid;

    vecs.push_back(mk(18'h00100,  1,  0, 100, 0, 1, 1, 18'h00100, 18'h00100));
    vecs.push_back(mk(18'h00000, 16,  0, 100, 0, 1, 1, 18'h00000, 18'h0003C));
    vecs.push_back(mk(18'h00200, 20, 30, 100, 3, 1, 4, 18'h00200, 18'h0024C));
    vecs.push_back(mk(18'h3FFF8,  4,  0, 100, 0, 1, 1, 18'h3FFF8, 18'h00004));
    vecs.push_back(mk(18'h01003,  3, 20,  50, 0, 1, 3, 18'h01000, 18'h01008));
    for (int i = 0; i < 5; i++) begin
      ra = ADDR_W'($urandom);
      rn = $urandom_range(40, 1);
      rf = ra & ~ADDR_W'(3);
      vecs.push_back(mk(ra, rn, $urandom_range(50, 0), $urandom_range(100, 30), 0,
                        1, $urandom_range(5, 1), rf, rf + ADDR_W'(4 * (rn - 1))));
    end

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Zero-length command completes the cycle after start with no bus traffic.
    wait_pct = 0; ready_pct = 100; ready_period = 0; lat_min = 1; lat_max = 1;
    kick(18'h00080, 0, 1'b0);
    check("zero_done_next_cycle", {done, busy, avm_read}, 3'b100);
    @(posedge clk); #1;
    check("zero_done_one_cycle", done, 0);
    finish_cmd("zero", 0, '0, '0);

    // A second start one cycle later must be ignored.
    kick(18'h00400, 4, 1'b1);
    wait_done(400, "dup_start");
    finish_cmd("dup_start", 4, 18'h00400, 18'h0040C);

    // Reset with reads in flight; their late returns must be dropped.
    lat_min = 4; lat_max = 4;
    kick(18'h00000, 32, 1'b0);
    guard = 0;
    while (acc_n - rv_n < 3 && guard < 50) begin @(posedge clk); #1; guard++; end
    check("outstanding_before_reset", 64'(acc_n - rv_n >= 3), 1);
    reset = 1'b1;
    gen++;
    exp_addr_q.delete(); exp_beat_q.delete();
    acc_n = 0; rv_n = 0; pop_n = 0; max_occ = 0;
    prev_wait_stall = 1'b0; prev_src_stall = 1'b0;
    @(posedge clk); #1;
    check_reset_values("mid_reset");
    reset = 1'b0;
    saw_valid = 1'b0;
    repeat (12) begin @(posedge clk); #1; saw_valid |= src_valid | busy; end
    check("late_rvalid_ignored", saw_valid, 0);
    run_vec(mk(18'h00040, 2, 0, 100, 0, 1, 2, 18'h00040, 18'h00044), "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
